// File: rtl/sd_cmd_seq.sv
// SD command sequencer.
// Takes one request from the register block, prefixes CMD55 for application
// commands, drives the sd_cmd engine, checks each result, retries failed
// attempts after a gap measured in SD clock rising edges, and reports one
// consolidated result with a single-cycle done pulse.
module sd_cmd_seq #(
  parameter int MAX_RETRIES = 2,
  parameter int RETRY_GAP   = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sd_clk_strobe_rising,
  input  logic        i_request_valid,
  output logic        o_request_ready,
  input  logic [5:0]  i_request_index,
  input  logic [31:0] i_request_argument,
  input  logic        i_request_long_response,
  input  logic        i_request_skip_response,
  input  logic        i_request_app,
  input  logic        i_request_ignore_crc,
  input  logic [15:0] i_rca,
  output logic        o_done,
  output logic        o_error_timeout,
  output logic        o_error_crc,
  output logic        o_error_app,
  output logic [31:0] o_response,
  output logic [5:0]  o_response_index,
  output logic [1:0]  o_retries,
  output logic [5:0]  o_command_index,
  output logic [31:0] o_command_argument,
  output logic        o_command_long_response,
  output logic        o_command_skip_response,
  output logic        o_command_start,
  input  logic        i_command_busy,
  input  logic [5:0]  i_command_index,
  input  logic [31:0] i_command_response,
  input  logic        i_command_timeout,
  input  logic        i_command_response_crc_error
);

  localparam logic [1:0] MAX_R         = 2'(MAX_RETRIES);
  localparam logic [7:0] GAP_LOAD      = 8'(RETRY_GAP);
  localparam logic [5:0] APP_CMD_INDEX = 6'd55;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APP_ISSUE,
    S_APP_WAIT,
    S_CMD_ISSUE,
    S_CMD_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t      state;
  logic [5:0]  req_index;
  logic [31:0] req_argument;
  logic        req_long;
  logic        req_skip;
  logic        req_app;
  logic        req_ignore_crc;
  logic [15:0] req_rca;
  logic [7:0]  gap_cnt;
  logic        wait_first;

  logic        fail_timeout;
  logic        fail_crc;
  logic        fail_app;
  logic        fail_any;
  logic        phase_done;

  assign o_request_ready = (state == S_IDLE);

  // The engine raises busy one cycle after start, so the first wait cycle
  // cannot be trusted to mean "finished".
  assign phase_done = !wait_first && !i_command_busy;
  assign fail_any   = fail_timeout || fail_crc || fail_app;

  // Classify the engine result of the phase currently being waited on.
  always_comb begin
    fail_timeout = 1'b0;
    fail_crc     = 1'b0;
    fail_app     = 1'b0;
    if (state == S_APP_WAIT) begin
      if (i_command_timeout) begin
        fail_timeout = 1'b1;
      end else if (i_command_response_crc_error || (i_command_index != APP_CMD_INDEX)) begin
        fail_crc = 1'b1;
      end else if (!i_command_response[5]) begin
        fail_app = 1'b1;
      end
    end else if ((state == S_CMD_WAIT) && !req_skip) begin
      if (i_command_timeout) begin
        fail_timeout = 1'b1;
      end else if (!req_ignore_crc &&
                   (i_command_response_crc_error ||
                    (!req_long && (i_command_index != req_index)))) begin
        fail_crc = 1'b1;
      end
    end
  end

  // Sequencer FSM with registered engine interface and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state                   <= S_IDLE;
      req_index               <= '0;
      req_argument            <= '0;
      req_long                <= 1'b0;
      req_skip                <= 1'b0;
      req_app                 <= 1'b0;
      req_ignore_crc          <= 1'b0;
      req_rca                 <= '0;
      gap_cnt                 <= '0;
      wait_first              <= 1'b0;
      o_done                  <= 1'b0;
      o_error_timeout         <= 1'b0;
      o_error_crc             <= 1'b0;
      o_error_app             <= 1'b0;
      o_response              <= '0;
      o_response_index        <= '0;
      o_retries               <= '0;
      o_command_index         <= '0;
      o_command_argument      <= '0;
      o_command_long_response <= 1'b0;
      o_command_skip_response <= 1'b0;
      o_command_start         <= 1'b0;
    end else begin
      o_command_start <= 1'b0;
      o_done          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_request_valid) begin
            req_index       <= i_request_index;
            req_argument    <= i_request_argument;
            req_long        <= i_request_long_response;
            req_skip        <= i_request_skip_response;
            req_app         <= i_request_app;
            req_ignore_crc  <= i_request_ignore_crc;
            req_rca         <= i_rca;
            o_error_timeout <= 1'b0;
            o_error_crc     <= 1'b0;
            o_error_app     <= 1'b0;
            o_retries       <= '0;
            o_command_start <= 1'b1;
            // The first issue uses the live request so the start pulse
            // follows acceptance by one cycle.
            if (i_request_app) begin
              state                   <= S_APP_ISSUE;
              o_command_index         <= APP_CMD_INDEX;
              o_command_argument      <= {i_rca, 16'h0000};
              o_command_long_response <= 1'b0;
              o_command_skip_response <= 1'b0;
            end else begin
              state                   <= S_CMD_ISSUE;
              o_command_index         <= i_request_index;
              o_command_argument      <= i_request_argument;
              o_command_long_response <= i_request_long_response;
              o_command_skip_response <= i_request_skip_response;
            end
          end
        end

        S_APP_ISSUE: begin
          state      <= S_APP_WAIT;
          wait_first <= 1'b1;
        end

        S_CMD_ISSUE: begin
          state      <= S_CMD_WAIT;
          wait_first <= 1'b1;
        end

        S_APP_WAIT, S_CMD_WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (phase_done) begin
            if ((state == S_CMD_WAIT) && !i_command_timeout) begin
              o_response       <= i_command_response;
              o_response_index <= i_command_index;
            end
            if (fail_any) begin
              if (o_retries < MAX_R) begin
                o_retries <= o_retries + 2'd1;
                gap_cnt   <= GAP_LOAD;
                state     <= S_GAP;
              end else begin
                o_error_timeout <= fail_timeout;
                o_error_crc     <= fail_crc;
                o_error_app     <= fail_app;
                state           <= S_DONE;
              end
            end else if (state == S_APP_WAIT) begin
              state                   <= S_CMD_ISSUE;
              o_command_start         <= 1'b1;
              o_command_index         <= req_index;
              o_command_argument      <= req_argument;
              o_command_long_response <= req_long;
              o_command_skip_response <= req_skip;
            end else begin
              state <= S_DONE;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == 8'd0) begin
            // Restart the whole sequence, including CMD55 for app requests.
            o_command_start <= 1'b1;
            if (req_app) begin
              state                   <= S_APP_ISSUE;
              o_command_index         <= APP_CMD_INDEX;
              o_command_argument      <= {req_rca, 16'h0000};
              o_command_long_response <= 1'b0;
              o_command_skip_response <= 1'b0;
            end else begin
              state                   <= S_CMD_ISSUE;
              o_command_index         <= req_index;
              o_command_argument      <= req_argument;
              o_command_long_response <= req_long;
              o_command_skip_response <= req_skip;
            end
          end else if (i_sd_clk_strobe_rising) begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        S_DONE: begin
          o_done <= 1'b1;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Testbench for sd_cmd_seq: a scripted engine model answers each start pulse,
// a vector table drives requests, and a scoreboard checks each done pulse.
module tb_sd_cmd_seq;

  localparam int BUSY_LEN = 3;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_sd_clk_strobe_rising;
  logic        i_request_valid;
  logic        o_request_ready;
  logic [5:0]  i_request_index;
  logic [31:0] i_request_argument;
  logic        i_request_long_response;
  logic        i_request_skip_response;
  logic        i_request_app;
  logic        i_request_ignore_crc;
  logic [15:0] i_rca;
  logic        o_done;
  logic        o_error_timeout;
  logic        o_error_crc;
  logic        o_error_app;
  logic [31:0] o_response;
  logic [5:0]  o_response_index;
  logic [1:0]  o_retries;
  logic [5:0]  o_command_index;
  logic [31:0] o_command_argument;
  logic        o_command_long_response;
  logic        o_command_skip_response;
  logic        o_command_start;
  logic        i_command_busy;
  logic [5:0]  i_command_index;
  logic [31:0] i_command_response;
  logic        i_command_timeout;
  logic        i_command_response_crc_error;

  sd_cmd_seq #(.MAX_RETRIES(2), .RETRY_GAP(8)) dut (
    .i_clk                        (i_clk),
    .i_reset                      (i_reset),
    .i_sd_clk_strobe_rising       (i_sd_clk_strobe_rising),
    .i_request_valid              (i_request_valid),
    .o_request_ready              (o_request_ready),
    .i_request_index              (i_request_index),
    .i_request_argument           (i_request_argument),
    .i_request_long_response      (i_request_long_response),
    .i_request_skip_response      (i_request_skip_response),
    .i_request_app                (i_request_app),
    .i_request_ignore_crc         (i_request_ignore_crc),
    .i_rca                        (i_rca),
    .o_done                       (o_done),
    .o_error_timeout              (o_error_timeout),
    .o_error_crc                  (o_error_crc),
    .o_error_app                  (o_error_app),
    .o_response                   (o_response),
    .o_response_index             (o_response_index),
    .o_retries                    (o_retries),
    .o_command_index              (o_command_index),
    .o_command_argument           (o_command_argument),
    .o_command_long_response      (o_command_long_response),
    .o_command_skip_response      (o_command_skip_response),
    .o_command_start              (o_command_start),
    .i_command_busy               (i_command_busy),
    .i_command_index              (i_command_index),
    .i_command_response           (i_command_response),
    .i_command_timeout            (i_command_timeout),
    .i_command_response_crc_error (i_command_response_crc_error)
  );

  always #5 i_clk = ~i_clk;

  // One record per request: stimulus, scripted engine answers per attempt
  // (packed {attempt3, attempt2, attempt1, attempt0}), and expected result.
  typedef struct {
    logic            app, long_r, skip, ign;
    logic [5:0]      idx;
    logic [31:0]     arg;
    logic [15:0]     rca;
    logic [3:0][5:0]  e_idx;
    logic [3:0][31:0] e_resp;
    logic [3:0]      e_to, e_crc;
    int              n_starts;
    logic [3:0][5:0] s_idx;
    logic [31:0]     arg0;
    logic            x_to, x_crc, x_app;
    logic [1:0]      x_ret;
    logic            chk_resp;
    logic [31:0]     x_resp;
    logic [5:0]      x_ridx;
    int              min_gap;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  vec_t cur;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int attempt = 0;
  int accept_cyc = 0;
  int busyfall_cyc = 0;
  int nstarts = 0;
  int strobes_since = 0;
  int min_gap = 1000;
  int start_total = 0;
  int done_total = 0;
  int cur_vn = 0;
  logic [5:0] sidx_seen [4];

  task automatic chk(input string nm, input int vn, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL v%0d %s actual=0x%0h required=0x%0h", vn, nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial begin
    i_sd_clk_strobe_rising = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      i_sd_clk_strobe_rising = ((cyc % 4) == 0);
    end
  end

  // Engine model: busy low in the first cycle after start, then high for
  // BUSY_LEN cycles, then low with the scripted result of this attempt.
  initial begin
    int eng_cnt;
    int eng_k;
    eng_cnt = 0;
    eng_k = 0;
    i_command_busy = 1'b0;
    i_command_index = '0;
    i_command_response = '0;
    i_command_timeout = 1'b0;
    i_command_response_crc_error = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (o_command_start) begin
        eng_cnt = BUSY_LEN + 1;
        eng_k = (attempt > 3) ? 3 : attempt;
        attempt++;
        i_command_index = 6'h2A;
        i_command_response = 32'hBAD0BAD0;
        i_command_timeout = 1'b0;
        i_command_response_crc_error = 1'b1;
      end else if (eng_cnt > 0) begin
        i_command_busy = (eng_cnt <= BUSY_LEN);
        eng_cnt--;
      end else if (i_command_busy) begin
        i_command_busy = 1'b0;
        i_command_index = cur.e_idx[eng_k];
        i_command_response = cur.e_resp[eng_k];
        i_command_timeout = cur.e_to[eng_k];
        i_command_response_crc_error = cur.e_crc[eng_k];
        busyfall_cyc = cyc;
      end
    end
  end

  // Monitor: tracks start pulses and compares each done against the scoreboard.
  initial forever begin
    vec_t e;
    @(negedge i_clk);
    if (!i_reset) begin
      if (i_sd_clk_strobe_rising) strobes_since++;
      if (o_command_start) begin
        start_total++;
        if (nstarts == 0) begin
          chk("first_start_latency", cur_vn, 32'(cyc), 32'(accept_cyc + 1));
          chk("first_start_arg", cur_vn, o_command_argument, cur.arg0);
          chk("first_start_skip", cur_vn, 32'(o_command_skip_response), 32'(cur.app ? 1'b0 : cur.skip));
          chk("first_start_long", cur_vn, 32'(o_command_long_response), 32'(cur.app ? 1'b0 : cur.long_r));
        end else if (strobes_since < min_gap) begin
          min_gap = strobes_since;
        end
        if (nstarts < 4) sidx_seen[nstarts] = o_command_index;
        nstarts++;
        strobes_since = 0;
      end
      if (o_done) begin
        done_total++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", cur_vn, 32'(o_done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("done_latency", cur_vn, 32'(cyc), 32'(busyfall_cyc + 2));
          chk("n_starts", cur_vn, 32'(nstarts), 32'(e.n_starts));
          for (int k = 0; k < e.n_starts && k < 4; k++)
            chk($sformatf("start%0d_index", k), cur_vn, 32'(sidx_seen[k]), 32'(e.s_idx[k]));
          chk("error_timeout", cur_vn, 32'(o_error_timeout), 32'(e.x_to));
          chk("error_crc", cur_vn, 32'(o_error_crc), 32'(e.x_crc));
          chk("error_app", cur_vn, 32'(o_error_app), 32'(e.x_app));
          chk("retries", cur_vn, 32'(o_retries), 32'(e.x_ret));
          if (e.chk_resp) begin
            chk("response", cur_vn, o_response, e.x_resp);
            chk("response_index", cur_vn, 32'(o_response_index), 32'(e.x_ridx));
          end
          if (e.min_gap > 0)
            chk($sformatf("retry_gap_min_%0d", min_gap), cur_vn, 32'(min_gap >= e.min_gap), 32'd1);
        end
      end
    end
  end

  task automatic drive_req(input vec_t v, input int vn);
    bit got;
    cur = v;
    cur_vn = vn;
    attempt = 0;
    nstarts = 0;
    min_gap = 1000;
    strobes_since = 0;
    @(posedge i_clk);
    #1;
    i_request_index = v.idx;
    i_request_argument = v.arg;
    i_request_long_response = v.long_r;
    i_request_skip_response = v.skip;
    i_request_app = v.app;
    i_request_ignore_crc = v.ign;
    i_rca = v.rca;
    i_request_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge i_clk);
      if (o_request_ready) begin
        accept_cyc = cyc;
        got = 1'b1;
      end
    end
    @(posedge i_clk);
    #1;
    i_request_valid = 1'b0;
    // Request fields are junk from here on; the sequencer must use its copy.
    i_request_index = 6'($urandom);
    i_request_argument = $urandom;
    i_request_long_response = 1'($urandom);
    i_request_skip_response = 1'($urandom);
    i_request_app = 1'($urandom);
    i_request_ignore_crc = 1'($urandom);
    i_rca = 16'($urandom);
    if (!got) chk("accept_timeout", vn, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int vn);
    sb_q.push_back(v);
    drive_req(v, vn);
    for (int i = 0; i < 3000 && sb_q.size() != 0; i++) @(negedge i_clk);
    if (sb_q.size() != 0) begin
      chk("done_timeout", vn, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    repeat (3) @(negedge i_clk);
  endtask

  initial begin
    vec_t v;
    int st0, d0;
    bit found;

    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t v;
    int st0, d0;
    bit found;

    i_reset = 1'b1;
    i_request_valid = 1'b0;
    i_request_index = '0;
    i_request_argument = '0;
    i_request_long_response = 1'b0;
    i_request_skip_response = 1'b0;
    i_request_app = 1'b0;
    i_request_ignore_crc = 1'b0;
    i_rca = '0;

    // V0: CMD8 plain success
    v = '{default: 0};
    v.idx = 6'd8; v.arg = 32'h000001AA;
    v.e_idx = {6'd0, 6'd0, 6'd0, 6'd8}; v.e_resp = {32'd0, 32'd0, 32'd0, 32'h1AA};
    v.n_starts = 1; v.s_idx = {6'd0, 6'd0, 6'd0, 6'd8}; v.arg0 = 32'h1AA;
    v.chk_resp = 1; v.x_resp = 32'h1AA; v.x_ridx = 6'd8;
    vecs.push_back(v);
    // V1: ACMD41, R3 with bad CRC and index 63 ignored
    v = '{default: 0};
    v.app = 1; v.ign = 1; v.idx = 6'd41; v.arg = 32'h40FF8000; v.rca = 16'h0000;
    v.e_idx = {6'd0, 6'd0, 6'd63, 6'd55}; v.e_resp = {32'd0, 32'd0, 32'h80FF8000, 32'h120};
    v.e_crc = 4'b0010;
    v.n_starts = 2; v.s_idx = {6'd0, 6'd0, 6'd41, 6'd55}; v.arg0 = 32'h0;
    v.chk_resp = 1; v.x_resp = 32'h80FF8000; v.x_ridx = 6'd63;
    vecs.push_back(v);
    // V2: APP_CMD bit clear on every CMD55
    v = '{default: 0};
    v.app = 1; v.idx = 6'd41; v.arg = 32'h40FF8000; v.rca = 16'h1234;
    v.e_idx = {6'd55, 6'd55, 6'd55, 6'd55}; v.e_resp = {32'h100, 32'h100, 32'h100, 32'h100};
    v.n_starts = 3; v.s_idx = {6'd0, 6'd55, 6'd55, 6'd55}; v.arg0 = 32'h12340000;
    v.x_app = 1; v.x_ret = 2; v.min_gap = 8;
    vecs.push_back(v);
    // V3: CMD17 times out once, then succeeds
    v = '{default: 0};
    v.idx = 6'd17; v.arg = 32'h00001000;
    v.e_idx = {6'd0, 6'd0, 6'd17, 6'd17}; v.e_resp = {32'd0, 32'd0, 32'h900, 32'd0};
    v.e_to = 4'b0001;
    v.n_starts = 2; v.s_idx = {6'd0, 6'd0, 6'd17, 6'd17}; v.arg0 = 32'h1000;
    v.x_ret = 1; v.chk_resp = 1; v.x_resp = 32'h900; v.x_ridx = 6'd17; v.min_gap = 8;
    vecs.push_back(v);
    // V4: CMD0 skip response, engine timeout ignored
    v = '{default: 0};
    v.idx = 6'd0; v.skip = 1; v.e_to = 4'b1111;
    v.n_starts = 1; v.arg0 = 32'h0;
    vecs.push_back(v);
    // V5: CMD2 long response, index not checked
    v = '{default: 0};
    v.idx = 6'd2; v.long_r = 1; v.arg = 32'h0;
    v.e_idx = {6'd0, 6'd0, 6'd0, 6'd63}; v.e_resp = {32'd0, 32'd0, 32'd0, 32'hDEADBEEF};
    v.n_starts = 1; v.s_idx = {6'd0, 6'd0, 6'd0, 6'd2};
    v.chk_resp = 1; v.x_resp = 32'hDEADBEEF; v.x_ridx = 6'd63;
    vecs.push_back(v);
    // V6: CMD13 CRC error on every attempt
    v = '{default: 0};
    v.idx = 6'd13; v.arg = 32'h12340000;
    v.e_idx = {6'd13, 6'd13, 6'd13, 6'd13}; v.e_resp = {32'h900, 32'h900, 32'h900, 32'h900};
    v.e_crc = 4'b1111;
    v.n_starts = 3; v.s_idx = {6'd0, 6'd13, 6'd13, 6'd13}; v.arg0 = 32'h12340000;
    v.x_crc = 1; v.x_ret = 2; v.chk_resp = 1; v.x_resp = 32'h900; v.x_ridx = 6'd13; v.min_gap = 8;
    vecs.push_back(v);
    // V7: CMD7 index mismatch once, then success
    v = '{default: 0};
    v.idx = 6'd7; v.arg = 32'h56780000;
    v.e_idx = {6'd0, 6'd0, 6'd7, 6'd3}; v.e_resp = {32'd0, 32'd0, 32'h700, 32'h300};
    v.n_starts = 2; v.s_idx = {6'd0, 6'd0, 6'd7, 6'd7}; v.arg0 = 32'h56780000;
    v.x_ret = 1; v.chk_resp = 1; v.x_resp = 32'h700; v.x_ridx = 6'd7;
    vecs.push_back(v);
    // V8: ACMD6 whose CMD phase times out once; CMD55 is repeated
    v = '{default: 0};
    v.app = 1; v.idx = 6'd6; v.arg = 32'h00000002; v.rca = 16'hABCD;
    v.e_idx = {6'd6, 6'd55, 6'd6, 6'd55}; v.e_resp = {32'h900, 32'h120, 32'd0, 32'h120};
    v.e_to = 4'b0010;
    v.n_starts = 4; v.s_idx = {6'd6, 6'd55, 6'd6, 6'd55}; v.arg0 = 32'hABCD0000;
    v.x_ret = 1; v.chk_resp = 1; v.x_resp = 32'h900; v.x_ridx = 6'd6;
    vecs.push_back(v);
    // V9: CMD55 times out every attempt
    v = '{default: 0};
    v.app = 1; v.idx = 6'd41; v.rca = 16'h0001; v.e_to = 4'b1111;
    v.n_starts = 3; v.s_idx = {6'd0, 6'd55, 6'd55, 6'd55}; v.arg0 = 32'h00010000;
    v.x_to = 1; v.x_ret = 2;
    vecs.push_back(v);
    // V10: CMD55 answered with the wrong index every attempt
    v = '{default: 0};
    v.app = 1; v.idx = 6'd51; v.rca = 16'h0002;
    v.e_resp = {32'h120, 32'h120, 32'h120, 32'h120};
    v.n_starts = 3; v.s_idx = {6'd0, 6'd55, 6'd55, 6'd55}; v.arg0 = 32'h00020000;
    v.x_crc = 1; v.x_ret = 2;
    vecs.push_back(v);

    repeat (3) @(negedge i_clk);
    chk("rst_ready", 99, 32'(o_request_ready), 32'd1);
    chk("rst_done", 99, 32'(o_done), 32'd0);
    chk("rst_start", 99, 32'(o_command_start), 32'd0);
    chk("rst_retries", 99, 32'(o_retries), 32'd0);
    chk("rst_errors", 99, 32'({o_error_timeout, o_error_crc, o_error_app}), 32'd0);
    chk("rst_response", 99, o_response, 32'd0);
    chk("rst_cmd_index", 99, 32'(o_command_index), 32'd0);
    chk("rst_cmd_arg", 99, o_command_argument, 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);

    for (int n = 0; n < vecs.size(); n++) run_vec(vecs[n], n);

    // Reset while waiting on the engine: back to idle, no done, no start.
    drive_req(vecs[3], 50);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge i_clk);
      if (o_command_start) found = 1'b1;
    end
    chk("midrst_start_seen", 50, 32'(found), 32'd1);
    repeat (2) @(negedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    st0 = start_total;
    d0 = done_total;
    @(posedge i_clk);
    #1;
    chk("midrst_ready", 50, 32'(o_request_ready), 32'd1);
    chk("midrst_start_low", 50, 32'(o_command_start), 32'd0);
    chk("midrst_done_low", 50, 32'(o_done), 32'd0);
    i_reset = 1'b0;
    repeat (25) @(negedge i_clk);
    chk("midrst_no_start", 50, 32'(start_total), 32'(st0));
    chk("midrst_no_done", 50, 32'(done_total), 32'(d0));

    run_vec(vecs[0], 51);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
